// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled
// JTAG TAP core running entirely in the system clock domain. The raw JTAG
// pins are synchronised and TCK is edge-detected, so the IEEE 1149.1 state
// machine, the instruction register and the IDCODE/BYPASS data registers
// are all plain clk-domain logic. DR scans that select an external channel
// are forwarded as one-cycle capture/shift/update strobes.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   tck_i, tms_i,     raw asynchronous JTAG pins
//   tdi_i, trst_n_i
//   tdo_o, tdo_oen    TDO data and active-low output enable
//   tap_state         current TAP state (0 = TLR ... F = UPD_IR)
//   ir_value          current (updated) instruction
//   chan_capture,     one-cycle strobes for the selected external channel
//   chan_shift,
//   chan_update
//   chan_tdi          TDI bit accompanying chan_shift
//   chan_tdo          LSB of each channel's shift register
module jtag_tap_oversampled #(
    parameter int unsigned IR_WIDTH     = 5,
    parameter int unsigned NUM_CHAN     = 4,
    parameter int unsigned CHAN_IR_BASE = 32'h10,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    input  logic                trst_n_i,
    output logic                tdo_o,
    output logic                tdo_oen,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [NUM_CHAN-1:0] chan_capture,
    output logic [NUM_CHAN-1:0] chan_shift,
    output logic [NUM_CHAN-1:0] chan_update,
    output logic                chan_tdi,
    input  logic [NUM_CHAN-1:0] chan_tdo
);

    typedef enum logic [3:0] {
        ST_TLR    = 4'h0,
        ST_RTI    = 4'h1,
        ST_SEL_DR = 4'h2,
        ST_CAP_DR = 4'h3,
        ST_SH_DR  = 4'h4,
        ST_EX1_DR = 4'h5,
        ST_PAU_DR = 4'h6,
        ST_EX2_DR = 4'h7,
        ST_UPD_DR = 4'h8,
        ST_SEL_IR = 4'h9,
        ST_CAP_IR = 4'hA,
        ST_SH_IR  = 4'hB,
        ST_EX1_IR = 4'hC,
        ST_PAU_IR = 4'hD,
        ST_EX2_IR = 4'hE,
        ST_UPD_IR = 4'hF
    } tap_state_e;

    // IEEE 1149.1 TAP transition table
    function automatic tap_state_e tap_next(input tap_state_e cur, input logic tms);
        case (cur)
            ST_TLR:    tap_next = tms ? ST_TLR    : ST_RTI;
            ST_RTI:    tap_next = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: tap_next = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: tap_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  tap_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: tap_next = tms ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: tap_next = tms ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: tap_next = tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: tap_next = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: tap_next = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: tap_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  tap_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: tap_next = tms ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: tap_next = tms ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: tap_next = tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: tap_next = tms ? ST_SEL_DR : ST_RTI;
            default:   tap_next = ST_TLR;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] tck_sync_r;
    logic [SYNC_STAGES-1:0] tms_sync_r;
    logic [SYNC_STAGES-1:0] tdi_sync_r;
    logic [SYNC_STAGES-1:0] trst_sync_r;
    logic                   tck_s;
    logic                   tms_s;
    logic                   tdi_s;
    logic                   trst_n_s;

    logic                   tck_prev_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   tms_smp_r;
    logic                   tdi_smp_r;

    tap_state_e             state_r;
    tap_state_e             state_next_s;

    logic [IR_WIDTH-1:0]    ir_sr_r;
    logic [31:0]            idcode_sr_r;
    logic                   bypass_r;

    logic [31:0]            ir_ext_s;
    logic                   sel_idcode_s;
    logic                   ir_all_ones_s;
    logic [NUM_CHAN-1:0]    chan_sel_s;
    logic                   dr_tdo_s;

    assign tck_s    = tck_sync_r[SYNC_STAGES-1];
    assign tms_s    = tms_sync_r[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_r[SYNC_STAGES-1];
    assign trst_n_s = trst_sync_r[SYNC_STAGES-1];

    // Pin synchronisers; reset to the idle pin levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync_r  <= {SYNC_STAGES{1'b0}};
            tms_sync_r  <= {SYNC_STAGES{1'b1}};
            tdi_sync_r  <= {SYNC_STAGES{1'b0}};
            trst_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            tck_sync_r  <= {tck_sync_r[SYNC_STAGES-2:0], tck_i};
            tms_sync_r  <= {tms_sync_r[SYNC_STAGES-2:0], tms_i};
            tdi_sync_r  <= {tdi_sync_r[SYNC_STAGES-2:0], tdi_i};
            trst_sync_r <= {trst_sync_r[SYNC_STAGES-2:0], trst_n_i};
        end
    end

    // TCK edge detection; TMS/TDI are sampled alongside so they line up with rise_r
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_prev_r <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            tms_smp_r  <= 1'b1;
            tdi_smp_r  <= 1'b0;
        end else begin
            tck_prev_r <= tck_s;
            rise_r     <= tck_s & ~tck_prev_r;
            fall_r     <= ~tck_s & tck_prev_r;
            tms_smp_r  <= tms_s;
            tdi_smp_r  <= tdi_s;
        end
    end

    // TAP next-state: TRST dominates, otherwise advance only on a TCK rise
    always_comb begin
        state_next_s = state_r;
        if (!trst_n_s) begin
            state_next_s = ST_TLR;
        end else if (rise_r) begin
            state_next_s = tap_next(state_r, tms_smp_r);
        end else begin
            state_next_s = state_r;
        end
    end

    // TAP state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign tap_state = state_r;

    // Instruction decode; IDCODE and all-ones take precedence over channel codes
    assign ir_ext_s      = 32'(ir_value);
    assign sel_idcode_s  = (ir_value == IR_WIDTH'(1));
    assign ir_all_ones_s = &ir_value;

    // One-hot channel select from the current instruction
    always_comb begin
        chan_sel_s = {NUM_CHAN{1'b0}};
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (!sel_idcode_s && !ir_all_ones_s &&
                (ir_ext_s == CHAN_IR_BASE + 32'(k))) begin
                chan_sel_s[k] = 1'b1;
            end else begin
                chan_sel_s[k] = 1'b0;
            end
        end
    end

    // LSB of whichever data register the instruction selects
    always_comb begin
        dr_tdo_s = bypass_r;
        if (sel_idcode_s) begin
            dr_tdo_s = idcode_sr_r[0];
        end else if (|chan_sel_s) begin
            dr_tdo_s = |(chan_sel_s & chan_tdo);
        end else begin
            dr_tdo_s = bypass_r;
        end
    end

    // Rising-edge register actions, strobes and falling-edge TDO update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_sr_r      <= IR_WIDTH'(1);
            ir_value     <= IR_WIDTH'(1);
            idcode_sr_r  <= 32'h0000_0000;
            bypass_r     <= 1'b0;
            tdo_o        <= 1'b0;
            tdo_oen      <= 1'b1;
            chan_capture <= {NUM_CHAN{1'b0}};
            chan_shift   <= {NUM_CHAN{1'b0}};
            chan_update  <= {NUM_CHAN{1'b0}};
            chan_tdi     <= 1'b0;
        end else if (!trst_n_s) begin
            ir_value     <= IR_WIDTH'(1);
            tdo_oen      <= 1'b1;
            chan_capture <= {NUM_CHAN{1'b0}};
            chan_shift   <= {NUM_CHAN{1'b0}};
            chan_update  <= {NUM_CHAN{1'b0}};
        end else begin
            chan_capture <= {NUM_CHAN{1'b0}};
            chan_shift   <= {NUM_CHAN{1'b0}};
            chan_update  <= {NUM_CHAN{1'b0}};
            if (rise_r) begin
                case (state_r)
                    ST_CAP_IR: ir_sr_r <= IR_WIDTH'(1);
                    ST_SH_IR:  ir_sr_r <= {tdi_smp_r, ir_sr_r[IR_WIDTH-1:1]};
                    ST_UPD_IR: ir_value <= ir_sr_r;
                    ST_CAP_DR: begin
                        if (sel_idcode_s) begin
                            idcode_sr_r <= IDCODE_VAL;
                        end
                        bypass_r     <= 1'b0;
                        chan_capture <= chan_sel_s;
                    end
                    ST_SH_DR: begin
                        if (sel_idcode_s) begin
                            idcode_sr_r <= {tdi_smp_r, idcode_sr_r[31:1]};
                        end
                        bypass_r   <= tdi_smp_r;
                        chan_shift <= chan_sel_s;
                        if (|chan_sel_s) begin
                            chan_tdi <= tdi_smp_r;
                        end
                    end
                    ST_UPD_DR: chan_update <= chan_sel_s;
                    default: ;
                endcase
                // Reaching TLR through TMS restores the IDCODE instruction
                if (state_next_s == ST_TLR) begin
                    ir_value <= IR_WIDTH'(1);
                end
            end
            if (fall_r) begin
                case (state_r)
                    ST_SH_IR: begin
                        tdo_o   <= ir_sr_r[0];
                        tdo_oen <= 1'b0;
                    end
                    ST_SH_DR: begin
                        tdo_o   <= dr_tdo_s;
                        tdo_oen <= 1'b0;
                    end
                    default: tdo_oen <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
module tb_jtag_tap_oversampled;

    localparam int          S   = 2;
    localparam int          IRW = 5;
    localparam int          NC  = 4;
    localparam logic [31:0] IDV = 32'h1000_0001;

    logic           clk = 1'b0;
    logic           rst;
    logic           tck_i, tms_i, tdi_i, trst_n_i;
    logic           tdo_o, tdo_oen;
    logic [3:0]     tap_state;
    logic [IRW-1:0] ir_value;
    logic [NC-1:0]  chan_capture, chan_shift, chan_update;
    logic           chan_tdi;
    logic [NC-1:0]  chan_tdo;

    jtag_tap_oversampled #(
        .IR_WIDTH(IRW), .NUM_CHAN(NC), .CHAN_IR_BASE(32'h10),
        .IDCODE_VAL(IDV), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .rst(rst), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .trst_n_i(trst_n_i), .tdo_o(tdo_o), .tdo_oen(tdo_oen),
        .tap_state(tap_state), .ir_value(ir_value),
        .chan_capture(chan_capture), .chan_shift(chan_shift),
        .chan_update(chan_update), .chan_tdi(chan_tdi), .chan_tdo(chan_tdo)
    );

    always #5 clk = ~clk;

    // Simple external channel model: 8-bit shift register per channel,
    // capture value 0x30+k, plus strobe counters.
    logic [7:0] ch_sr [NC] = '{default: 8'h00};
    int cap_cnt [NC] = '{default: 0};
    int sh_cnt  [NC] = '{default: 0};
    int up_cnt  [NC] = '{default: 0};
    int b_cap [NC];
    int b_sh  [NC];
    int b_up  [NC];

    always @(negedge clk) begin
        for (int k = 0; k < NC; k++) begin
            if (chan_capture[k]) begin
                ch_sr[k]   <= 8'h30 + 8'(k);
                cap_cnt[k] <= cap_cnt[k] + 1;
            end
            if (chan_shift[k]) begin
                ch_sr[k]  <= {chan_tdi, ch_sr[k][7:1]};
                sh_cnt[k] <= sh_cnt[k] + 1;
            end
            if (chan_update[k]) begin
                up_cnt[k] <= up_cnt[k] + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NC; k++) chan_tdo[k] = ch_sr[k][0];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int half     = 6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One TCK period; returns TDO/OEN as seen after the falling edge settles
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_s, output logic oen_s);
        tms_i = tms;
        tdi_i = tdi;
        repeat (2) @(negedge clk);
        tck_i = 1'b1;
        repeat (half) @(negedge clk);
        tck_i = 1'b0;
        repeat (half) @(negedge clk);
        tdo_s = tdo_o;
        oen_s = tdo_oen;
    endtask

    task automatic tck_tms(input logic tms);
        logic t, o;
        tck_cycle(tms, 1'b0, t, o);
    endtask

    // Full IR or DR scan from RTI back to RTI; dout collects TDO LSB-first
    task automatic scan(input logic is_ir, input int n, input logic [31:0] din,
                        output logic [31:0] dout, output logic oen_ok);
        logic t, o;
        dout   = 32'h0;
        oen_ok = 1'b1;
        tck_tms(1'b1);
        if (is_ir) tck_tms(1'b1);
        tck_tms(1'b0);
        tck_cycle(1'b0, 1'b0, t, o);
        dout[0] = t;
        if (o !== 1'b0) oen_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            tck_cycle((i == n - 1), din[i], t, o);
            if (i < n - 1) begin
                dout[i+1] = t;
                if (o !== 1'b0) oen_ok = 1'b0;
            end else if (o !== 1'b1) begin
                oen_ok = 1'b0;
            end
        end
        tck_tms(1'b1);
        tck_tms(1'b0);
    endtask

    task automatic snap();
        for (int k = 0; k < NC; k++) begin
            b_cap[k] = cap_cnt[k];
            b_sh[k]  = sh_cnt[k];
            b_up[k]  = up_cnt[k];
        end
    endtask

    // Strobe counts since snap(): only channel sel may have activity
    task automatic check_strobes(input string tag, input int sel, input int nsh, input int nup);
        for (int k = 0; k < NC; k++) begin
            check($sformatf("%s_cap%0d", tag, k), 32'(cap_cnt[k] - b_cap[k]), (k == sel) ? 32'd1 : 32'd0);
            check($sformatf("%s_sh%0d", tag, k), 32'(sh_cnt[k] - b_sh[k]), (k == sel) ? 32'(nsh) : 32'd0);
            check($sformatf("%s_up%0d", tag, k), 32'(up_cnt[k] - b_up[k]), (k == sel) ? 32'(nup) : 32'd0);
        end
    endtask

    typedef struct packed {
        logic       tms;
        logic [3:0] st;
        logic       oen;
    } walk_t;

    walk_t walk [26];

    initial begin
        logic [31:0] dout;
        logic        ok;
        logic [31:0] exp_v;
        logic [31:0] din;
        logic [31:0] code;
        logic [31:0] codes [7];
        int          n;

        walk = '{
            '{1'b1, 4'h2, 1'b1}, '{1'b0, 4'h3, 1'b1}, '{1'b0, 4'h4, 1'b0}, '{1'b1, 4'h5, 1'b1},
            '{1'b0, 4'h6, 1'b1}, '{1'b1, 4'h7, 1'b1}, '{1'b0, 4'h4, 1'b0}, '{1'b1, 4'h5, 1'b1},
            '{1'b1, 4'h8, 1'b1}, '{1'b1, 4'h2, 1'b1}, '{1'b1, 4'h9, 1'b1}, '{1'b0, 4'hA, 1'b1},
            '{1'b0, 4'hB, 1'b0}, '{1'b1, 4'hC, 1'b1}, '{1'b0, 4'hD, 1'b1}, '{1'b1, 4'hE, 1'b1},
            '{1'b1, 4'hF, 1'b1}, '{1'b0, 4'h1, 1'b1}, '{1'b1, 4'h2, 1'b1}, '{1'b0, 4'h3, 1'b1},
            '{1'b0, 4'h4, 1'b0}, '{1'b1, 4'h5, 1'b1}, '{1'b1, 4'h8, 1'b1}, '{1'b1, 4'h2, 1'b1},
            '{1'b1, 4'h9, 1'b1}, '{1'b1, 4'h0, 1'b1}
        };
        codes = '{32'h01, 32'h10, 32'h11, 32'h12, 32'h13, 32'h1F, 32'h05};

        // Reset state
        rst = 1'b1; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; trst_n_i = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_state", 32'(tap_state), 32'h0);
        check("rst_ir", 32'(ir_value), 32'h1);
        check("rst_tdo", 32'(tdo_o), 32'h0);
        check("rst_oen", 32'(tdo_oen), 32'h1);
        check("rst_strobes", 32'({chan_capture, chan_shift, chan_update}), 32'h0);
        check("rst_chan_tdi", 32'(chan_tdi), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Pin-to-state latency: TLR -> RTI
        tms_i = 1'b0;
        repeat (2) @(negedge clk);
        tck_i = 1'b1;
        n = 0;
        while (n < 20 && tap_state !== 4'h1) begin
            @(negedge clk);
            n++;
        end
        check("rise_latency", 32'(n), 32'(S + 2));
        tck_i = 1'b0;
        repeat (half) @(negedge clk);

        // State walk through all 16 states, ending with TMS=1 x5 from SH_DR
        for (int i = 0; i < 26; i++) begin
            logic t, o;
            tck_cycle(walk[i].tms, 1'b0, t, o);
            check($sformatf("walk%0d_state", i), 32'(tap_state), 32'(walk[i].st));
            check($sformatf("walk%0d_oen", i), 32'(o), 32'(walk[i].oen));
        end
        check("walk_ir_tlr", 32'(ir_value), 32'h1);

        // IDCODE scan
        tck_tms(1'b0);
        scan(1'b0, 32, 32'h0, dout, ok);
        check("idcode", dout, IDV);
        check("idcode_oen", 32'(ok), 32'h1);

        // IR 0x11 then channel 1 DR scan
        scan(1'b1, IRW, 32'h11, dout, ok);
        check("ir_capture", dout & 32'h1F, 32'h01);
        check("ir_oen", 32'(ok), 32'h1);
        check("ir_value_11", 32'(ir_value), 32'h11);
        snap();
        scan(1'b0, 8, 32'h96, dout, ok);
        check("chan1_out", dout & 32'hFF, 32'h31);
        check("chan1_in", 32'(ch_sr[1]), 32'h96);
        check_strobes("chan1", 1, 8, 1);

        // BYPASS via all-ones and via an unmapped code
        scan(1'b1, IRW, 32'h1F, dout, ok);
        check("ir_value_1f", 32'(ir_value), 32'h1F);
        snap();
        scan(1'b0, 8, 32'hA5, dout, ok);
        check("bypass_1f", dout & 32'hFF, 32'h4A);
        check_strobes("byp1f", -1, 0, 0);
        scan(1'b1, IRW, 32'h07, dout, ok);
        scan(1'b0, 8, 32'hA5, dout, ok);
        check("bypass_07", dout & 32'hFF, 32'h4A);

        // TMS=1 x5 returns to TLR and restores IDCODE
        for (int i = 0; i < 5; i++) tck_tms(1'b1);
        check("tms5_state", 32'(tap_state), 32'h0);
        check("tms5_ir", 32'(ir_value), 32'h1);

        // TRST during SH_DR on channel 1
        tck_tms(1'b0);
        scan(1'b1, IRW, 32'h11, dout, ok);
        snap();
        tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0);
        tck_tms(1'b0); tck_tms(1'b0);
        check("pre_trst_state", 32'(tap_state), 32'h4);
        trst_n_i = 1'b0;
        n = 0;
        while (n < 10 && tap_state !== 4'h0) begin
            @(negedge clk);
            n++;
        end
        check("trst_latency_ok", 32'(n <= S + 1), 32'h1);
        check("trst_ir", 32'(ir_value), 32'h1);
        check("trst_oen", 32'(tdo_oen), 32'h1);
        tck_tms(1'b0);
        tck_tms(1'b0);
        check("trst_hold_state", 32'(tap_state), 32'h0);
        trst_n_i = 1'b1;
        repeat (6) @(negedge clk);
        check_strobes("trst", 1, 2, 0);

        // Asynchronous rst mid-scan on channel 2
        tck_tms(1'b0);
        scan(1'b1, IRW, 32'h12, dout, ok);
        snap();
        tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0); tck_tms(1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_state", 32'(tap_state), 32'h0);
        check("rst_mid_ir", 32'(ir_value), 32'h1);
        check("rst_mid_oen", 32'(tdo_oen), 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tck_tms(1'b1);
        tck_tms(1'b1);
        check_strobes("rstmid", 2, 1, 0);

        // Minimum TCK phase with a random IR/DR mix
        half = S + 3;
        tck_tms(1'b0);
        for (int it = 0; it < 6; it++) begin
            code = codes[$urandom_range(0, 6)];
            din  = $urandom & 32'hFF;
            scan(1'b1, IRW, code, dout, ok);
            check($sformatf("mix%0d_ir", it), 32'(ir_value), code);
            scan(1'b0, 8, din, dout, ok);
            if (code == 32'h01) begin
                exp_v = IDV & 32'hFF;
            end else if (code >= 32'h10 && code <= 32'h13) begin
                exp_v = 32'h30 + (code - 32'h10);
                check($sformatf("mix%0d_chan_in", it), 32'(ch_sr[code - 32'h10]), din);
            end else begin
                exp_v = (din << 1) & 32'hFF;
            end
            check($sformatf("mix%0d_out", it), dout & 32'hFF, exp_v);
            check($sformatf("mix%0d_oen", it), 32'(ok), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
